// File: rtl/frost32_cpu_pkg.sv
// frost32_cpu_pkg: shared types, encodings and decode helpers for the Frost32 core
package frost32_cpu_pkg;
  localparam int WORD_W = 32;
  localparam int NUM_REGS = 16;
  localparam int REG_IDX_W = 4;
  localparam int OP_W = 4;
  localparam int IMM_W = 16;
  typedef enum logic {DiatRead, DiatWrite} data_inout_access_type_t;
  typedef enum logic [1:0] {Dias32, Dias16, Dias8} data_inout_access_size_t;
  typedef struct packed {
    logic [WORD_W-1:0] data;
  } port_in_t;
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] addr;
    logic req_mem_access;
    data_inout_access_type_t data_inout_access_type;
    data_inout_access_size_t data_inout_access_size;
  } port_out_t;
  typedef enum logic [1:0] {StFetch, StExecute, StMem} state_t;
  localparam logic [3:0] GRP_ALU = 4'd0;
  localparam logic [3:0] GRP_ALUI = 4'd1;
  localparam logic [3:0] GRP_BRANCH = 4'd2;
  localparam logic [3:0] GRP_LDST = 4'd3;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_SLTS = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_ORR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_LSL = 4'd8;
  localparam logic [3:0] ALU_LSR = 4'd9;
  localparam logic [3:0] ALU_ASR = 4'd10;
  localparam logic [3:0] ALUI_CPYHI = 4'd9;
  localparam logic [3:0] BR_BEQ = 4'd0;
  localparam logic [3:0] BR_BNE = 4'd1;
  localparam logic [3:0] BR_BLTU = 4'd2;
  localparam logic [3:0] BR_JMP = 4'd4;
  localparam logic [3:0] BR_CALL = 4'd5;
  localparam logic [3:0] LD_B = 4'd2;
  localparam logic [3:0] ST_B = 4'd5;
  // grp1 lacks slts and nor, so its opcodes slide onto the grp0 ALU codes
  function automatic logic [OP_W-1:0] alui_op(logic [OP_W-1:0] op);
    return op < 4'd3 ? op : op < 4'd6 ? op + 4'd1 : op + 4'd2;
  endfunction
  function automatic data_inout_access_size_t ldst_size(logic [OP_W-1:0] op);
    return (op == 4'd1 || op == 4'd4) ? Dias16 : (op == 4'd2 || op == 4'd5) ? Dias8 : Dias32;
  endfunction
endpackage

// File: rtl/frost32_cpu_if.sv
// frost32_cpu_if: shared memory port between the core and its memory
interface frost32_cpu_if;
  import frost32_cpu_pkg::*;
  port_in_t in;
  port_out_t out;
  modport master(input in, output out);
  modport slave(output in, input out);
endinterface

// File: rtl/frost32_alu.sv
// frost32_alu: combinational ALU used by register, immediate and branch-compare paths
module frost32_alu
  import frost32_cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLTU: y = {31'd0, a < b};
      ALU_SLTS: y = {31'd0, $signed(a) < $signed(b)};
      ALU_AND:  y = a & b;
      ALU_ORR:  y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_LSL:  y = a << b[4:0];
      ALU_LSR:  y = a >> b[4:0];
      ALU_ASR:  y = $signed(a) >>> b[4:0];
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/frost32.sv
// frost32_cpu: multi-cycle 32-bit core, fetch/execute/mem over one big-endian memory port
module frost32_cpu
  import frost32_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic clk,
  input logic rst,
  frost32_cpu_if.master bus
);
  state_t st_q, st_d;
  logic [WORD_W-1:0] pc_q, pc_d, instr_q, instr_d;
  logic [WORD_W-1:0] regs_q [NUM_REGS];
  logic [WORD_W-1:0] regs_d [NUM_REGS];
  logic [3:0] grp, ra, rb, rc, op0, op, alu_op;
  logic [IMM_W-1:0] imm;
  logic [WORD_W-1:0] ra_v, rb_v, rc_v, imm_s, imm_z, alu_a, alu_b, alu_y, ea, pc4, ld_data, st_data, wd;
  logic taken, is_load, is_store, we, in_mem;
  data_inout_access_size_t msize;
  port_out_t o;
  assign grp = instr_q[31:28];
  assign ra = instr_q[27:24];
  assign rb = instr_q[23:20];
  assign rc = instr_q[19:16];
  assign op = instr_q[19:16];
  assign op0 = instr_q[15:12];
  assign imm = instr_q[15:0];
  assign ra_v = regs_q[ra];
  assign rb_v = regs_q[rb];
  assign rc_v = regs_q[rc];
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_z = {16'h0, imm};
  assign pc4 = pc_q + 32'd4;
  assign ea = rb_v + imm_s;
  assign is_load = op <= LD_B;
  assign is_store = op > LD_B && op <= ST_B;
  assign msize = ldst_size(op);
  // branches reuse the ALU: xor for equality, sltu for unsigned ordering
  always_comb begin
    alu_a = grp == GRP_BRANCH ? ra_v : rb_v;
    alu_b = grp == GRP_ALU ? rc_v : grp == GRP_BRANCH ? rb_v : op < 4'd3 ? imm_s : imm_z;
    alu_op = grp == GRP_ALU ? op0 : grp == GRP_BRANCH ? (op < BR_BLTU ? ALU_XOR : ALU_SLTU) : alui_op(op);
  end
  frost32_alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y));
  always_comb begin
    taken = op == BR_BEQ ? alu_y == '0 : op == BR_BNE ? alu_y != '0 : op == BR_BLTU ? alu_y[0] : !alu_y[0];
    ld_data = msize == Dias16 ? {16'h0, bus.in.data[15:0]} : msize == Dias8 ? {24'h0, bus.in.data[7:0]} : bus.in.data;
    st_data = msize == Dias16 ? {16'h0, ra_v[15:0]} : msize == Dias8 ? {24'h0, ra_v[7:0]} : ra_v;
  end
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    instr_d = instr_q;
    we = 1'b0;
    wd = alu_y;
    if (st_q == StFetch) begin
      instr_d = bus.in.data;
      st_d = StExecute;
    end else if (st_q == StExecute) begin
      pc_d = pc4;
      st_d = StFetch;
      case (grp)
        GRP_ALU: we = (op0 <= ALU_ASR);
        GRP_ALUI: begin
          we = (op <= ALUI_CPYHI);
          wd = op == ALUI_CPYHI ? {imm, 16'h0} : alu_y;
        end
        GRP_BRANCH: begin
          pc_d = op < BR_JMP ? (taken ? pc4 + imm_s : pc4) : op == BR_JMP ? ra_v : op == BR_CALL ? rb_v : pc4;
          we = (op == BR_CALL);
          wd = pc4;
        end
        GRP_LDST: if (op <= ST_B) begin
          pc_d = pc_q;
          st_d = StMem;
        end
        default: ;
      endcase
    end else begin
      pc_d = pc4;
      st_d = StFetch;
      we = is_load;
      wd = ld_data;
    end
    regs_d = regs_q;
    if (we && ra != 4'd0) regs_d[ra] = wd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= StFetch;
      pc_q <= RESET_PC;
      instr_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      regs_q <= regs_d;
    end
  end
  // rst gates the port directly so a request never survives the cycle reset is sampled
  always_comb begin
    in_mem = !rst && st_q == StMem;
    o.req_mem_access = !rst && st_q != StExecute;
    o.addr = rst ? '0 : st_q == StFetch ? pc_q : in_mem ? ea : '0;
    o.data_inout_access_type = in_mem && is_store ? DiatWrite : DiatRead;
    o.data_inout_access_size = in_mem ? msize : Dias32;
    o.data = in_mem && is_store ? st_data : '0;
  end
  assign bus.out = o;
endmodule

// File: tb/tb_frost32_cpu.sv
// tb_frost32_cpu: ISA-level reference model predicts every bus transaction and its cycle
module tb_frost32_cpu;
  import frost32_cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  frost32_cpu_if bus();
  frost32_cpu #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [31:0] addr;
    data_inout_access_type_t t;
    data_inout_access_size_t s;
    logic [31:0] data;
  } txn_t;
  logic [7:0] mem [4096];
  logic [7:0] m_mem [4096];
  logic [31:0] m_r [16];
  logic [31:0] m_pc;
  logic [31:0] prog [$];
  txn_t q [$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] rd_a;
  logic [31:0] rd_w;
  always_comb begin
    rd_a = bus.out.addr[11:0];
    rd_w = {mem[rd_a], mem[rd_a + 12'd1], mem[rd_a + 12'd2], mem[rd_a + 12'd3]};
    bus.in.data = bus.out.data_inout_access_size == Dias16 ? {16'h0, rd_w[31:16]} :
                  bus.out.data_inout_access_size == Dias8 ? {24'h0, rd_w[31:24]} : rd_w;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mrd(input logic [31:0] addr, input data_inout_access_size_t s);
    logic [11:0] a;
    logic [31:0] w;
    a = addr[11:0];
    w = {m_mem[a], m_mem[a + 12'd1], m_mem[a + 12'd2], m_mem[a + 12'd3]};
    return s == Dias16 ? {16'h0, w[31:16]} : s == Dias8 ? {24'h0, w[31:24]} : w;
  endfunction
  function automatic logic [31:0] memw(input logic [11:0] a);
    return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
  endfunction
  task automatic wr(input bit to_model, input logic [31:0] addr, input data_inout_access_size_t s, input logic [31:0] d);
    logic [7:0] b [4];
    int n;
    b = '{d[31:24], d[23:16], d[15:8], d[7:0]};
    n = s == Dias32 ? 4 : s == Dias16 ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      if (to_model) m_mem[addr[11:0] + 12'(i)] = b[4 - n + i];
      else mem[addr[11:0] + 12'(i)] = b[4 - n + i];
    end
  endtask
  function automatic logic [31:0] e0(input int a, input int b, input int c, input int op);
    return {4'd0, 4'(a), 4'(b), 4'(c), 4'(op), 12'h0};
  endfunction
  function automatic logic [31:0] ei(input int g, input int a, input int b, input int op, input int imm);
    return {4'(g), 4'(a), 4'(b), 4'(op), 16'(imm)};
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [3:0] g;
    g = $urandom_range(0, 9) == 0 ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    return {g, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 11)), 16'($urandom)};
  endfunction
  // sequential ISA interpreter: fetch at c, ALU/branch next fetch at c+2, load/store access at c+2 and next fetch at c+3
  task automatic model_run(input int n);
    int c;
    logic [31:0] ins, a_v, b_v, c_v, imm_s, imm_z, res, nxt, pc4, ea;
    logic [3:0] g, ra, op, op0;
    logic [4:0] sh;
    bit wen;
    data_inout_access_size_t s;
    c = 0;
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    for (int i = 0; i < n; i++) begin
      ins = mrd(m_pc, Dias32);
      q.push_back('{cyc: c, addr: m_pc, t: DiatRead, s: Dias32, data: 32'h0});
      g = ins[31:28];
      ra = ins[27:24];
      op = ins[19:16];
      op0 = ins[15:12];
      a_v = m_r[ra];
      b_v = m_r[ins[23:20]];
      c_v = m_r[ins[19:16]];
      imm_s = {{16{ins[15]}}, ins[15:0]};
      imm_z = {16'h0, ins[15:0]};
      pc4 = m_pc + 32'd4;
      nxt = pc4;
      res = 32'h0;
      wen = 1'b0;
      if (g == 4'd0) begin
        sh = c_v[4:0];
        wen = op0 <= 4'd10;
        case (op0)
          4'd0: res = b_v + c_v;
          4'd1: res = b_v - c_v;
          4'd2: res = b_v < c_v ? 32'd1 : 32'd0;
          4'd3: res = $signed(b_v) < $signed(c_v) ? 32'd1 : 32'd0;
          4'd4: res = b_v & c_v;
          4'd5: res = b_v | c_v;
          4'd6: res = b_v ^ c_v;
          4'd7: res = ~(b_v | c_v);
          4'd8: res = b_v << sh;
          4'd9: res = b_v >> sh;
          4'd10: res = $signed(b_v) >>> sh;
          default: res = 32'h0;
        endcase
      end else if (g == 4'd1) begin
        sh = ins[4:0];
        wen = op <= 4'd9;
        case (op)
          4'd0: res = b_v + imm_s;
          4'd1: res = b_v - imm_s;
          4'd2: res = b_v < imm_s ? 32'd1 : 32'd0;
          4'd3: res = b_v & imm_z;
          4'd4: res = b_v | imm_z;
          4'd5: res = b_v ^ imm_z;
          4'd6: res = b_v << sh;
          4'd7: res = b_v >> sh;
          4'd8: res = $signed(b_v) >>> sh;
          4'd9: res = {ins[15:0], 16'h0};
          default: res = 32'h0;
        endcase
      end else if (g == 4'd2) begin
        case (op)
          4'd0: if (a_v == b_v) nxt = pc4 + imm_s;
          4'd1: if (a_v != b_v) nxt = pc4 + imm_s;
          4'd2: if (a_v < b_v) nxt = pc4 + imm_s;
          4'd3: if (a_v >= b_v) nxt = pc4 + imm_s;
          4'd4: nxt = a_v;
          4'd5: begin
            res = pc4;
            wen = 1'b1;
            nxt = b_v;
          end
          default: ;
        endcase
      end else if (g == 4'd3 && op <= 4'd5) begin
        ea = b_v + imm_s;
        s = (op == 4'd1 || op == 4'd4) ? Dias16 : (op == 4'd2 || op == 4'd5) ? Dias8 : Dias32;
        if (op <= 4'd2) begin
          q.push_back('{cyc: c + 2, addr: ea, t: DiatRead, s: s, data: 32'h0});
          res = mrd(ea, s);
          wen = 1'b1;
        end else begin
          res = s == Dias32 ? a_v : s == Dias16 ? {16'h0, a_v[15:0]} : {24'h0, a_v[7:0]};
          q.push_back('{cyc: c + 2, addr: ea, t: DiatWrite, s: s, data: res});
          wr(1'b1, ea, s, res);
        end
        c++;
      end
      if (wen && ra != 4'd0) m_r[ra] = res;
      m_pc = nxt;
      c += 2;
    end
  endtask
  task automatic reset_phase();
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h0;
      m_mem[i] = 8'h0;
    end
    foreach (prog[i]) begin
      wr(1'b0, 32'(i * 4), Dias32, prog[i]);
      wr(1'b1, 32'(i * 4), Dias32, prog[i]);
    end
    repeat (2) begin
      @(negedge clk);
      chk("rst_req", {31'b0, bus.out.req_mem_access}, 32'h0);
      chk("rst_addr", bus.out.addr, 32'h0);
      chk("rst_data", bus.out.data, 32'h0);
      chk("rst_type", 32'(bus.out.data_inout_access_type), 32'(DiatRead));
      chk("rst_size", 32'(bus.out.data_inout_access_size), 32'(Dias32));
    end
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run_test(input int n);
    int c, budget;
    bit exp_req;
    txn_t e;
    reset_phase();
    q.delete();
    model_run(n);
    budget = q[$].cyc + 4;
    release_rst();
    c = 0;
    while (q.size() > 0 && c <= budget) begin
      @(negedge clk);
      exp_req = q[0].cyc == c;
      chk("req", {31'b0, bus.out.req_mem_access}, {31'b0, exp_req});
      if (exp_req) begin
        e = q.pop_front();
        if (bus.out.req_mem_access) begin
          chk("addr", bus.out.addr, e.addr);
          chk("type", 32'(bus.out.data_inout_access_type), 32'(e.t));
          chk("size", 32'(bus.out.data_inout_access_size), 32'(e.s));
          if (e.t == DiatWrite) chk("wdata", bus.out.data, e.data);
        end
      end
      if (bus.out.req_mem_access && bus.out.data_inout_access_type == DiatWrite)
        wr(1'b0, bus.out.addr, bus.out.data_inout_access_size, bus.out.data);
      c++;
    end
    chk("outstanding", 32'(q.size()), 32'h0);
    q.delete();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    prog = {ei(1, 1, 0, 0, 5), ei(1, 2, 0, 0, 16'hFFFD), e0(3, 1, 2, 0), ei(1, 1, 0, 9, 16'h1234),
            ei(1, 1, 1, 4, 16'h5678), ei(3, 1, 0, 3, 16'h100), ei(3, 4, 0, 1, 16'h102), ei(3, 5, 0, 2, 16'h100),
            ei(3, 3, 0, 3, 16'h104), e0(0, 1, 1, 0), ei(3, 0, 0, 3, 16'h108), ei(2, 0, 0, 1, 8),
            ei(1, 6, 0, 0, 16'h40), ei(3, 4, 0, 3, 16'h10C), ei(2, 14, 6, 5, 0), 32'h0,
            ei(3, 14, 0, 3, 16'h110), ei(3, 5, 0, 5, 16'h114), ei(2, 0, 0, 0, 16'hFFFC)};
    run_test(21);
    chk("str_cpyhi_orri", memw(12'h100), 32'h1234_5678);
    chk("add_r3", memw(12'h104), 32'h2);
    chk("r0_discard", memw(12'h108), 32'h0);
    chk("ldh_r4", memw(12'h10C), 32'h0000_5678);
    chk("call_link", memw(12'h110), 32'h3C);
    chk("stb_r5", {24'h0, mem[12'h114]}, 32'h12);
    prog = {ei(1, 1, 0, 0, 16'h77), ei(3, 1, 0, 3, 16'h200), ei(2, 0, 0, 0, 16'hFFFC)};
    reset_phase();
    release_rst();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out.req_mem_access && bus.out.data_inout_access_type == DiatWrite) break;
    end
    chk("abort_store_seen", {31'b0, bus.out.req_mem_access && bus.out.data_inout_access_type == DiatWrite}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_req", {31'b0, bus.out.req_mem_access}, 32'h0);
    chk("abort_type", 32'(bus.out.data_inout_access_type), 32'(DiatRead));
    @(posedge clk);
    #1;
    chk("abort_pc", dut.pc_q, 32'h0);
    chk("abort_mem", memw(12'h200), 32'h0);
    run_test(6);
    for (int s = 0; s < 3; s++) begin
      prog.delete();
      for (int i = 0; i < 1024; i++) prog.push_back(rnd_instr());
      run_test(300);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
